nim_game_ctrl: RTL

Top-level sequencer for the two-player heap-taking game. It owns the page state machine (start, help, heap-count select, game, game over), the 40-bit heap board, and turn arbitration. It validates and commits moves proposed by the cursor/chooser block and counts round wins.
It sits between the PS2 key decoder (one-cycle key pulses) and the display/chooser logic, which read `status`, `player` and `page`.

---
 rtl/nim_pkg.sv | 39 +++
 rtl/nim_move_checker.sv | 37 +++
 rtl/nim_game_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/nim_pkg.sv
// nim_pkg: shared definitions for the heap-taking game controller.
//   - page_e      : page encoding driven on nim_game_ctrl.page
//   - HEAP_W      : width of one heap field in the board
//   - MAX_HEAPS   : number of heap fields in the 40-bit board
//   - RESET_BOARD : board value held while in reset
//   - load_board  : fresh board for a given heap count
//   - sat_inc4    : saturating 4-bit increment for the win counters
package nim_pkg;

    typedef enum logic [2:0] {
        PAGE_START  = 3'd0,
        PAGE_HELP   = 3'd1,
        PAGE_SELECT = 3'd2,
        PAGE_GAME   = 3'd3,
        PAGE_OVER   = 3'd4
    } page_e;

    localparam int HEAP_W    = 4;
    localparam int MAX_HEAPS = 10;
    localparam int BOARD_W   = HEAP_W * MAX_HEAPS;

    localparam logic [BOARD_W-1:0] RESET_BOARD = 40'h11_1111_1111;

    // Heap i starts at i+1 while i < n; heaps beyond the selected count are empty.
    function automatic logic [BOARD_W-1:0] load_board(input logic [3:0] n);
        logic [BOARD_W-1:0] b;
        b = '0;
        for (int i = 0; i < MAX_HEAPS; i++) begin
            b[i*HEAP_W +: HEAP_W] = (4'(i) < n) ? 4'(i + 1) : 4'd0;
        end
        return b;
    endfunction

    // Win counters stick at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : (v + 4'd1);
    endfunction

endpackage

// File: rtl/nim_move_checker.sv
// nim_move_checker: combinational move validation.
//   status     in  40  current board
//   num        in  4   selected heap count
//   move_index in  4   heap to change (0-based)
//   move_value in  4   proposed new heap value
//   legal      out 1   index inside the selected heaps and value strictly smaller
//   next_board out 40  board with the proposed value written in
//   all_zero   out 1   next_board has every heap empty
module nim_move_checker
    import nim_pkg::*;
(
    input  logic [BOARD_W-1:0] status,
    input  logic [3:0]         num,
    input  logic [3:0]         move_index,
    input  logic [3:0]         move_value,
    output logic               legal,
    output logic [BOARD_W-1:0] next_board,
    output logic               all_zero
);

    logic [HEAP_W-1:0] cur_heap_s;

    // Select the addressed heap and build the post-move board; indexes past
    // the last heap field select nothing and leave the board untouched.
    always_comb begin
        cur_heap_s = '0;
        next_board = status;
        for (int i = 0; i < MAX_HEAPS; i++) begin
            cur_heap_s = (move_index == 4'(i)) ? status[i*HEAP_W +: HEAP_W] : cur_heap_s;
            next_board[i*HEAP_W +: HEAP_W] = (move_index == 4'(i)) ? move_value
                                                                  : status[i*HEAP_W +: HEAP_W];
        end
        legal    = (move_index < num) && (move_value < cur_heap_s);
        all_zero = (next_board == '0);
    end

endmodule

// File: rtl/nim_game_ctrl.sv
// nim_game_ctrl: page sequencer, heap board owner and turn arbiter.
//   clk, rst                      clock, async active-high reset
//   key_up/down/enter/space/quit  one-cycle key pulses from the PS2 decoder
//   move_valid/index/value        move proposed by the chooser
//   move_ack / move_err           one-cycle result of a proposed move
//   status                        40-bit board, heap i at [4i+3:4i]
//   player                        side to move
//   page                          current page (nim_pkg::page_e)
//   num                           selected heap count
//   win0 / win1                   rounds won per player
//   winner                        match winner, meaningful on page OVER
// NUM_HEAPS_MAX must not exceed nim_pkg::MAX_HEAPS.
module nim_game_ctrl
    import nim_pkg::*;
#(
    parameter int NUM_HEAPS_MAX = 10,
    parameter int DEFAULT_NUM   = 3,
    parameter int ROUNDS_TO_WIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_enter,
    input  logic               key_space,
    input  logic               key_quit,
    input  logic               move_valid,
    input  logic [3:0]         move_index,
    input  logic [3:0]         move_value,
    output logic               move_ack,
    output logic               move_err,
    output logic [BOARD_W-1:0] status,
    output logic               player,
    output logic [2:0]         page,
    output logic [3:0]         num,
    output logic [3:0]         win0,
    output logic [3:0]         win1,
    output logic               winner
);

    page_e              page_q,   page_d;
    logic [BOARD_W-1:0] status_q, status_d;
    logic               player_q, player_d;
    logic [3:0]         num_q,    num_d;
    logic [3:0]         win0_q,   win0_d;
    logic [3:0]         win1_q,   win1_d;
    logic               winner_q, winner_d;
    logic               ack_q,    ack_d;
    logic               err_q,    err_d;

    logic               legal_s;
    logic               all_zero_s;
    logic [BOARD_W-1:0] next_board_s;
    logic [3:0]         mover_wins_s;

    nim_move_checker u_checker (
        .status     (status_q),
        .num        (num_q),
        .move_index (move_index),
        .move_value (move_value),
        .legal      (legal_s),
        .next_board (next_board_s),
        .all_zero   (all_zero_s)
    );

    // State register for page, board, turn, counters and handshake pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_q   <= PAGE_START;
            status_q <= RESET_BOARD;
            player_q <= 1'b0;
            num_q    <= 4'(DEFAULT_NUM);
            win0_q   <= 4'd0;
            win1_q   <= 4'd0;
            winner_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            page_q   <= page_d;
            status_q <= status_d;
            player_q <= player_d;
            num_q    <= num_d;
            win0_q   <= win0_d;
            win1_q   <= win1_d;
            winner_q <= winner_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: page transitions, board loads and move commit.
    always_comb begin
        page_d       = page_q;
        status_d     = status_q;
        player_d     = player_q;
        num_d        = num_q;
        win0_d       = win0_q;
        win1_d       = win1_q;
        winner_d     = winner_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        mover_wins_s = sat_inc4(player_q ? win1_q : win0_q);

        case (page_q)
            PAGE_START: begin
                if (key_enter) begin
                    page_d = PAGE_SELECT;
                end else if (key_space) begin
                    page_d = PAGE_HELP;
                end else begin
                    page_d = PAGE_START;
                end
            end
            PAGE_HELP: begin
                if (key_enter) begin
                    page_d = PAGE_SELECT;
                end else if (key_space || key_quit) begin
                    page_d = PAGE_START;
                end else begin
                    page_d = PAGE_HELP;
                end
            end
            PAGE_SELECT: begin
                if (key_enter) begin
                    page_d   = PAGE_GAME;
                    status_d = load_board(num_q);
                end else if (key_quit) begin
                    page_d = PAGE_START;
                end else if (key_up && !key_down) begin
                    num_d = (num_q == 4'(NUM_HEAPS_MAX)) ? 4'd1 : (num_q + 4'd1);
                end else if (key_down && !key_up) begin
                    num_d = (num_q == 4'd1) ? 4'(NUM_HEAPS_MAX) : (num_q - 4'd1);
                end else begin
                    num_d = num_q;
                end
            end
            PAGE_GAME: begin
                // Quit overrides a simultaneous move, which is dropped silently.
                if (key_quit) begin
                    page_d   = PAGE_START;
                    win0_d   = 4'd0;
                    win1_d   = 4'd0;
                    player_d = 1'b0;
                end else if (move_valid && legal_s) begin
                    ack_d    = 1'b1;
                    player_d = ~player_q;
                    if (all_zero_s) begin
                        if (player_q) begin
                            win1_d = mover_wins_s;
                        end else begin
                            win0_d = mover_wins_s;
                        end
                        if (mover_wins_s == 4'(ROUNDS_TO_WIN)) begin
                            page_d   = PAGE_OVER;
                            winner_d = player_q;
                            status_d = next_board_s;
                        end else begin
                            // The emptied board is never shown; the next round starts at once.
                            status_d = load_board(num_q);
                        end
                    end else begin
                        status_d = next_board_s;
                    end
                end else if (move_valid) begin
                    err_d = 1'b1;
                end else begin
                    page_d = PAGE_GAME;
                end
            end
            PAGE_OVER: begin
                if (key_enter) begin
                    page_d   = PAGE_START;
                    win0_d   = 4'd0;
                    win1_d   = 4'd0;
                    player_d = 1'b0;
                end else begin
                    page_d = PAGE_OVER;
                end
            end
            default: begin
                page_d = PAGE_START;
            end
        endcase
    end

    assign page     = page_q;
    assign status   = status_q;
    assign player   = player_q;
    assign num      = num_q;
    assign win0     = win0_q;
    assign win1     = win1_q;
    assign winner   = winner_q;
    assign move_ack = ack_q;
    assign move_err = err_q;

endmodule
